// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Gshare branch direction predictor. A pattern history table (PHT) of
// 2^IDX_W saturating counters is indexed by the word-aligned fetch PC xor'd
// with a global history register (GHR). The prediction is the counter MSB.
//
// Lookup is purely combinational. Training happens at the rising clock edge
// using the index that was produced at fetch and carried down to execute.
// The GHR is non-speculative: it records resolved outcomes only.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_lookup_pc    fetch-stage PC (bits [1:0] ignored)
//   o_pred_taken   predicted direction for i_lookup_pc
//   o_pred_idx     PHT index used for the lookup
//   i_update_en    a conditional branch resolved this cycle
//   i_update_idx   PHT index of the resolving branch
//   i_update_taken resolved direction
//   i_clear        synchronous clear of PHT and GHR (wins over an update)
//   o_ghr          current global history
// -----------------------------------------------------------------------------
module gshare_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int GHR_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PC_W-1:0]  i_lookup_pc,
  output logic             o_pred_taken,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_update_en,
  input  logic [IDX_W-1:0] i_update_idx,
  input  logic             i_update_taken,
  input  logic             i_clear,
  output logic [GHR_W-1:0] o_ghr
);

  localparam int DEPTH = 1 << IDX_W;

  // Weakly-not-taken: 0111..1, i.e. one below the taken threshold.
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pht [DEPTH];
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] lookup_idx;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  logic [GHR_W-1:0] ghr_next;

  // Only the word-index bits of the PC feed the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_lookup_pc[PC_W-1:IDX_W+2], i_lookup_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: history is zero-extended to the index width before hashing.
  // Reads the current (pre-update) table; there is deliberately no bypass.
  // ---------------------------------------------------------------------------
  assign lookup_idx   = i_lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign o_pred_idx   = lookup_idx;
  assign o_pred_taken = pht[lookup_idx][CNT_W-1];
  assign o_ghr        = ghr;

  // ---------------------------------------------------------------------------
  // Saturating counter next value for the entry being trained.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns cnt_next -- no latch inferred.
    cnt_cur  = pht[i_update_idx];
    cnt_next = cnt_cur;
    if (i_update_taken) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0)      cnt_next = cnt_cur - CNT_W'(1);
    end
  end

  // Shift the resolved outcome in at the LSB; truncation drops the oldest bit.
  // Works unchanged for GHR_W == 1, where the history is just the last outcome.
  assign ghr_next = GHR_W'({ghr, i_update_taken});

  // ---------------------------------------------------------------------------
  // State: PHT and GHR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the table is flops, not SRAM, so every entry gets a reset value;
      // an un-reset table would predict X until each entry was trained.
      for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_WNT;
      ghr <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_WNT;
      ghr <= '0;
    end else if (i_update_en) begin
      // NOTE: non-blocking assignments keep the same-cycle lookup reading the
      // old counter and old history, with the new values visible next cycle.
      pht[i_update_idx] <= cnt_next;
      ghr               <= ghr_next;
    end
  end

endmodule
